// File: rtl/hazard_unit.sv
// Pipeline hazard controller: memory freeze, branch flush, load-use bubble, memory timeout fault.
// Event counters are built only when HAZARD_STATS_EN is defined; otherwise the ports read 0.
module hazard_unit #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  addr1DEC,
  input  logic [4:0]  addr2DEC,
  input  logic        use1DEC,
  input  logic        use2DEC,
  input  logic [4:0]  rdEXE,
  input  logic        WregEXE,
  input  logic        memReadEXE,
  input  logic        branchTakenEXE,
  input  logic        memReqMEM,
  input  logic        memAckMEM,
  output logic        stallPC,
  output logic        stallDEC,
  output logic        stallEXE,
  output logic        stallMEM,
  output logic        bubbleEXE,
  output logic        flushDEC,
  output logic        memError,
  output logic [31:0] stallCycles,
  output logic [31:0] loadUseCount,
  output logic [31:0] flushCount
);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       freeze;
  logic       load_use;
  logic       lu_apply;
  logic       flush_apply;
  logic       timeout_hit;

  assign freeze   = memReqMEM && !memAckMEM;
  assign load_use = memReadEXE && WregEXE && (rdEXE != 5'd0) &&
                    ((use1DEC && (addr1DEC == rdEXE)) || (use2DEC && (addr2DEC == rdEXE)));
  // Compared in 9 bits so the counter can never wrap before ERROR is taken.
  assign timeout_hit = (9'(wait_cnt_q) + 9'd1) >= 9'(MEM_TIMEOUT);

  always_comb begin
    stallPC     = 1'b0;
    stallDEC    = 1'b0;
    stallEXE    = 1'b0;
    stallMEM    = 1'b0;
    bubbleEXE   = 1'b0;
    flushDEC    = 1'b0;
    memError    = 1'b0;
    lu_apply    = 1'b0;
    flush_apply = 1'b0;
    if (state_q == StError) begin
      stallPC  = 1'b1;
      stallDEC = 1'b1;
      stallEXE = 1'b1;
      stallMEM = 1'b1;
      memError = 1'b1;
    end else if (freeze) begin
      stallPC  = 1'b1;
      stallDEC = 1'b1;
      stallEXE = 1'b1;
      stallMEM = 1'b1;
    end else if (branchTakenEXE) begin
      flushDEC    = 1'b1;
      bubbleEXE   = 1'b1;
      flush_apply = 1'b1;
    end else if (load_use) begin
      stallPC   = 1'b1;
      stallDEC  = 1'b1;
      bubbleEXE = 1'b1;
      lu_apply  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      StRun: begin
        if (freeze) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd0;
        end
      end
      StMemWait: begin
        if (!freeze) begin
          state_d = StRun;
        end else if (timeout_hit) begin
          state_d = StError;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StError: state_d = StError;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StRun;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, load_use_cnt_q, flush_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      load_use_cnt_q <= 32'd0;
      flush_cnt_q    <= 32'd0;
    end else begin
      if (stallPC)     stall_cycles_q <= stall_cycles_q + 32'd1;
      if (lu_apply)    load_use_cnt_q <= load_use_cnt_q + 32'd1;
      if (flush_apply) flush_cnt_q    <= flush_cnt_q + 32'd1;
    end
  end

  assign stallCycles  = stall_cycles_q;
  assign loadUseCount = load_use_cnt_q;
  assign flushCount   = flush_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = lu_apply ^ flush_apply;
  assign stallCycles  = 32'd0;
  assign loadUseCount = 32'd0;
  assign flushCount   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: per-cycle reference model of the hazard rules plus directed scenarios
// with literal expectations. Counter expectations follow HAZARD_STATS_EN.
module tb_hazard_unit;

  localparam logic [7:0] TO = 8'd4;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  addr1DEC, addr2DEC, rdEXE;
  logic        use1DEC, use2DEC, WregEXE, memReadEXE, branchTakenEXE, memReqMEM, memAckMEM;
  logic        stallPC, stallDEC, stallEXE, stallMEM, bubbleEXE, flushDEC, memError;
  logic [31:0] stallCycles, loadUseCount, flushCount;

  hazard_unit #(.MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .addr1DEC(addr1DEC), .addr2DEC(addr2DEC), .use1DEC(use1DEC), .use2DEC(use2DEC),
    .rdEXE(rdEXE), .WregEXE(WregEXE), .memReadEXE(memReadEXE),
    .branchTakenEXE(branchTakenEXE), .memReqMEM(memReqMEM), .memAckMEM(memAckMEM),
    .stallPC(stallPC), .stallDEC(stallDEC), .stallEXE(stallEXE), .stallMEM(stallMEM),
    .bubbleEXE(bubbleEXE), .flushDEC(flushDEC), .memError(memError),
    .stallCycles(stallCycles), .loadUseCount(loadUseCount), .flushCount(flushCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = running, 1 = waiting on memory, 2 = faulted.
  int          mode = 0;
  int          waited = 0;
  bit          valid = 1'b0;
  logic [31:0] m_stall = 0, m_lu = 0, m_fl = 0;
  logic        fr, lu, e_stall, e_lu, e_fl, e_err;

  always @(negedge clock) begin
    fr = memReqMEM && !memAckMEM;
    lu = memReadEXE && WregEXE && (rdEXE != 0) &&
         ((use1DEC && addr1DEC == rdEXE) || (use2DEC && addr2DEC == rdEXE));
    e_stall = 0; e_lu = 0; e_fl = 0; e_err = 0;
    if (mode == 2) begin
      e_stall = 1; e_err = 1;
    end else if (fr) e_stall = 1;
    else if (branchTakenEXE) e_fl = 1;
    else if (lu) e_lu = 1;
    if (valid) begin
      check("m_stallPC",  {31'd0, stallPC},   {31'd0, e_stall | e_lu});
      check("m_stallDEC", {31'd0, stallDEC},  {31'd0, e_stall | e_lu});
      check("m_stallEXE", {31'd0, stallEXE},  {31'd0, e_stall});
      check("m_stallMEM", {31'd0, stallMEM},  {31'd0, e_stall});
      check("m_bubble",   {31'd0, bubbleEXE}, {31'd0, e_fl | e_lu});
      check("m_flush",    {31'd0, flushDEC},  {31'd0, e_fl});
      check("m_memError", {31'd0, memError},  {31'd0, e_err});
      check("m_stallCycles",  stallCycles,  STATS ? m_stall : 32'd0);
      check("m_loadUseCount", loadUseCount, STATS ? m_lu : 32'd0);
      check("m_flushCount",   flushCount,   STATS ? m_fl : 32'd0);
    end
    if (reset) begin
      mode = 0; waited = 0; m_stall = 0; m_lu = 0; m_fl = 0; valid = 1'b1;
    end else if (valid) begin
      m_stall += {31'd0, e_stall | e_lu};
      m_lu    += {31'd0, e_lu};
      m_fl    += {31'd0, e_fl};
      if (mode == 0 && fr) begin
        mode = 1; waited = 0;
      end else if (mode == 1) begin
        if (!fr) mode = 0;
        else begin
          waited++;
          if (waited >= int'(TO)) mode = 2;
        end
      end
    end
  end

  task automatic set_in(input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                        input logic u2, input logic [4:0] rd, input logic wr, input logic mr,
                        input logic br, input logic rq, input logic ak);
    addr1DEC = a1; use1DEC = u1; addr2DEC = a2; use2DEC = u2; rdEXE = rd;
    WregEXE = wr; memReadEXE = mr; branchTakenEXE = br; memReqMEM = rq; memAckMEM = ak;
  endtask

  task automatic idle();
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    next();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    next();
    next();
    reset = 1'b0;

    // Reset state
    neg();
    check("lit_rst_stallPC", {31'd0, stallPC}, 32'd0);
    check("lit_rst_memError", {31'd0, memError}, 32'd0);
    check("lit_rst_loadUseCount", loadUseCount, 32'd0);

    // Load x5 feeding rs1: one bubble cycle
    next();
    set_in(5'd5, 1'b1, 5'd9, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    neg();
    check("lit_lu_stallPC", {31'd0, stallPC}, 32'd1);
    check("lit_lu_stallDEC", {31'd0, stallDEC}, 32'd1);
    check("lit_lu_bubble", {31'd0, bubbleEXE}, 32'd1);
    check("lit_lu_stallEXE", {31'd0, stallEXE}, 32'd0);
    next();
    idle();
    neg();
    check("lit_lu_after_stallPC", {31'd0, stallPC}, 32'd0);
    check("lit_lu_count", loadUseCount, STATS ? 32'd1 : 32'd0);

    // rd = x0 and unused rs2 never stall
    next();
    set_in(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    neg();
    check("lit_x0_stallPC", {31'd0, stallPC}, 32'd0);
    next();
    set_in(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    neg();
    check("lit_nouse_stallPC", {31'd0, stallPC}, 32'd0);

    // Branch beats load-use
    next();
    do_reset();
    set_in(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    neg();
    check("lit_br_flush", {31'd0, flushDEC}, 32'd1);
    check("lit_br_bubble", {31'd0, bubbleEXE}, 32'd1);
    check("lit_br_stallPC", {31'd0, stallPC}, 32'd0);
    next();
    idle();
    neg();
    check("lit_br_flushCount", flushCount, STATS ? 32'd1 : 32'd0);
    check("lit_br_luCount", loadUseCount, 32'd0);

    // Memory freeze, ack on the fourth cycle
    next();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      neg();
      check("lit_frz_stallMEM", {31'd0, stallMEM}, 32'd1);
      next();
    end
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    neg();
    check("lit_ack_stallPC", {31'd0, stallPC}, 32'd0);
    next();
    idle();
    neg();
    check("lit_ack_run_stallPC", {31'd0, stallPC}, 32'd0);
    check("lit_ack_stallCycles", stallCycles, STATS ? 32'd3 : 32'd0);

    // Branch held during freeze, applied on the ack cycle
    next();
    for (int i = 0; i < 2; i++) begin
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      neg();
      check("lit_brfrz_flush", {31'd0, flushDEC}, 32'd0);
      next();
    end
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    neg();
    check("lit_brack_flush", {31'd0, flushDEC}, 32'd1);
    check("lit_brack_stallPC", {31'd0, stallPC}, 32'd0);

    // Timeout: one RUN freeze cycle plus four MEM_WAIT cycles, then ERROR
    next();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      neg();
      check("lit_to_pre_memError", {31'd0, memError}, 32'd0);
      next();
    end
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    neg();
    check("lit_err_memError", {31'd0, memError}, 32'd1);
    check("lit_err_stallPC", {31'd0, stallPC}, 32'd1);
    check("lit_err_flush", {31'd0, flushDEC}, 32'd0);
    next();
    reset = 1'b1;
    idle();
    neg();
    check("lit_err_rstcyc_memError", {31'd0, memError}, 32'd1);
    next();
    reset = 1'b0;
    neg();
    check("lit_err_cleared", {31'd0, memError}, 32'd0);
    check("lit_err_cleared_stallPC", {31'd0, stallPC}, 32'd0);

    // Reset in the middle of a memory wait
    next();
    for (int i = 0; i < 2; i++) begin
      set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      next();
    end
    reset = 1'b1;
    next();
    reset = 1'b0;
    idle();
    neg();
    check("lit_midwait_rst_stallPC", {31'd0, stallPC}, 32'd0);

    // Mixed traffic checked by the model alone
    next();
    for (int i = 0; i < 80; i++) begin
      set_in(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 1)));
      next();
    end
    do_reset();
    neg();
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
